wal_dot_acc: RTL and testbench
==============================

# wal_dot_acc

Downstream accumulation stage for the 4x4 Wallace tree multiplier (`fourwalmul`). It accepts one 8-bit product per valid/ready handshake and sums a fixed number of products into a dot-product result. It presents that result on an output valid/ready handshake. It turns the combinational multiplier into a sequential multiply-accumulate datapath for vector workloads.

## Interface
- `N_TERMS`, default 4: products per dot product; legal range 2..16.
- `ACC_W`, default 10: accumulator and result width; legal range 8..16.
- `CNT_W`, default 4: term-counter width; must satisfy 2^CNT_W >= N_TERMS.

Ports:
- `clk`  in  1  single clock; all state updates on the rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `clr`  in  1  synchronous abort; discards the partial sum.
- `in_valid`  in  1  `prod` is valid.
- `in_ready`  out  1  stage can accept a product.
- `prod`  in  8  unsigned product from `fourwalmul`.
- `out_valid`  out  1  `sum` and `ovf` are valid.
- `out_ready`  in  1  consumer accepts the result.
- `sum`  out  ACC_W  completed dot product.
- `ovf`  out  1  the result exceeded 2^ACC_W-1.
- `term_cnt`  out  CNT_W  products accepted so far in the current dot product.

## Operation
- States:
  - ACCUM: `in_ready`=1, `out_valid`=0.
  - HOLD: `in_ready`=0, `out_valid`=1.
- Transfer in: `in_valid && in_ready` at the rising edge. Transfer out: `out_valid && out_ready` at the rising edge.
- ACCUM, accepted product with `term_cnt` < N_TERMS-1:
  - `acc <= acc + prod` (zero-extended, ACC_W+1-bit add).
  - `term_cnt++`.
  - Carry out of the add sets the internal sticky overflow bit.
- ACCUM, accepted product with `term_cnt` == N_TERMS-1:
  - `sum <= acc + prod`.
  - `ovf <=` sticky bit OR carry of this add.
  - Go to HOLD. `acc`, `term_cnt` and the sticky bit clear to 0.
- HOLD:
  - `prod` and `in_valid` are ignored.
  - `sum` and `ovf` hold stable until the output transfer.
  - On the output transfer, go to ACCUM.
- `clr`, in any state:
  - Next state is ACCUM.
  - `acc`, `term_cnt`, the sticky bit, `out_valid` and `ovf` go to 0.
  - `sum` retains its last value.
  - `clr` has priority over a simultaneous input or output transfer; neither transfer takes effect.
- `in_valid` without `in_ready`: no effect. The producer holds `prod` until the transfer occurs.
- Reset (`rst_n`=0): every register clears immediately, asynchronously. An in-progress dot product is lost.

## Timing
- Reset values:
  - state = ACCUM
  - `in_ready`=1
  - `out_valid`=0
  - `sum`=0
  - `ovf`=0
  - `term_cnt`=0
- `in_ready` and `out_valid` are decoded directly from the state register, with no combinational path from `in_valid` or `out_ready`.
- Throughput: one product per cycle in ACCUM.
- Latency: `out_valid` rises on the same edge that accepts the last product.
- Minimum HOLD occupancy is 1 cycle, so back-to-back dot products have a 1-cycle input bubble.
- Peak rate: N_TERMS products per N_TERMS+1 cycles.
- `rst_n` deassertion is synchronised externally. The first transfer is permitted on the first edge after release.

## Configuration
- Macro `WAL_ACC_SAT_EN`:
  - Defined: on any overflow event the accumulator saturates to 2^ACC_W-1 and stays there for the rest of the dot product. `sum` = 2^ACC_W-1 and `ovf`=1.
  - Undefined: the accumulator wraps modulo 2^ACC_W and `ovf`=1 flags the wrap.
- `ovf` is produced in both builds.

## Test plan
- Basic sum, defaults: products 0, 2, 16, 25, one per cycle with `out_ready`=1.
  - Required: `out_valid` on the 4th accept edge, `sum`=43, `ovf`=0, `term_cnt` 0→1→2→3→0.
  - Then products 49, 64, 81, 100: `sum`=294.
- Backpressure: products 121, 121, 121, 121; hold `out_ready`=0 for 5 cycles with `in_valid`=1 and `prod`=9.
  - Required: `in_ready`=0 and `sum`=484 stable during the stall.
  - After `out_ready` rises, next dot product accepts 9 first.
- Overflow, ACC_W=8: products 121 ×4.
  - Without the macro: `sum`=228, `ovf`=1.
  - With `WAL_ACC_SAT_EN`: `sum`=255, `ovf`=1.
  - Next result 1+1+1+1 → `sum`=4, `ovf`=0.
- Clear: accept 100, 100; assert `clr` with `in_valid`=1 and `prod`=50.
  - Required: `term_cnt`=0 next cycle and the 50 is not summed.
  - Then 1, 2, 3, 4 → `sum`=10.
- Async reset mid-operation: accept 2 products, assert `rst_n`=0 between clock edges.
  - Required: outputs reach reset values immediately.
  - After release, 5, 5, 5, 5 → `sum`=20.
- Stall on input: toggle `in_valid` every other cycle with products 1, 2, 3, 4.
  - Required: `sum`=10 and only valid cycles are counted.

Source files
------------

// File: rtl/wal_dot_acc.sv
// wal_dot_acc: sums N_TERMS unsigned 8-bit products into one dot-product result with an overflow flag.
// Latency: result is valid on the same edge that accepts the last product; 1-cycle minimum HOLD bubble.
// Backpressure: in_ready drops while a result is held; result holds until out_ready. Macro WAL_ACC_SAT_EN selects saturation.
module wal_dot_acc #(
    parameter int N_TERMS = 4,
    parameter int ACC_W   = 10,
    parameter int CNT_W   = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             clr,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [7:0]       prod,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [ACC_W-1:0] sum,
    output logic             ovf,
    output logic [CNT_W-1:0] term_cnt
);

    typedef enum logic {
        ST_ACCUM = 1'b0,
        ST_HOLD  = 1'b1
    } state_t;

    localparam logic [ACC_W-1:0] ACC_MAX  = '1;
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(N_TERMS - 1);

    state_t           state_q, state_d;
    logic [ACC_W-1:0] acc_q, acc_d;
    logic [ACC_W-1:0] sum_q, sum_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             sticky_q, sticky_d;
    logic             ovf_q, ovf_d;

    logic [ACC_W:0]   add_w;
    logic             carry_w;
    logic             ovf_evt_w;
    logic [ACC_W-1:0] acc_next_w;
    logic             in_xfer_w;
    logic             out_xfer_w;
    logic             last_term_w;

    // One extra bit on the add so the carry is the overflow event for this term.
    assign add_w     = {1'b0, acc_q} + (ACC_W + 1)'(prod);
    assign carry_w   = add_w[ACC_W];
    assign ovf_evt_w = sticky_q | carry_w;

`ifdef WAL_ACC_SAT_EN
    // Once any overflow has happened the accumulator pins at full scale for the rest of the dot product.
    assign acc_next_w = ovf_evt_w ? ACC_MAX : add_w[ACC_W-1:0];
`else
    // Plain modulo-2^ACC_W wrap; the sticky bit alone records that a wrap occurred.
    assign acc_next_w = add_w[ACC_W-1:0];
`endif

    // Handshake outputs come straight from the state register, no path from in_valid/out_ready.
    assign in_ready    = (state_q == ST_ACCUM);
    assign out_valid   = (state_q == ST_HOLD);
    assign in_xfer_w   = in_valid & in_ready;
    assign out_xfer_w  = out_valid & out_ready;
    assign last_term_w = (cnt_q == LAST_CNT);

    assign sum      = sum_q;
    assign ovf      = ovf_q;
    assign term_cnt = cnt_q;

    // Next-state logic: clr overrides any transfer in either state.
    always_comb begin
        state_d  = state_q;
        acc_d    = acc_q;
        sum_d    = sum_q;
        cnt_d    = cnt_q;
        sticky_d = sticky_q;
        ovf_d    = ovf_q;
        if (clr) begin
            state_d  = ST_ACCUM;
            acc_d    = '0;
            cnt_d    = '0;
            sticky_d = 1'b0;
            ovf_d    = 1'b0;
        end else begin
            unique case (state_q)
                ST_ACCUM: begin
                    if (in_xfer_w) begin
                        if (last_term_w) begin
                            sum_d    = acc_next_w;
                            ovf_d    = ovf_evt_w;
                            acc_d    = '0;
                            cnt_d    = '0;
                            sticky_d = 1'b0;
                            state_d  = ST_HOLD;
                        end else begin
                            acc_d    = acc_next_w;
                            cnt_d    = cnt_q + 1'b1;
                            sticky_d = ovf_evt_w;
                        end
                    end
                end
                ST_HOLD: begin
                    if (out_xfer_w) begin
                        state_d = ST_ACCUM;
                    end
                end
                default: begin
                    state_d = ST_ACCUM;
                end
            endcase
        end
    end

    // State and datapath registers, cleared asynchronously by rst_n.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= ST_ACCUM;
            acc_q    <= '0;
            sum_q    <= '0;
            cnt_q    <= '0;
            sticky_q <= 1'b0;
            ovf_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            acc_q    <= acc_d;
            sum_q    <= sum_d;
            cnt_q    <= cnt_d;
            sticky_q <= sticky_d;
            ovf_q    <= ovf_d;
        end
    end

endmodule

// File: tb/tb_wal_dot_acc.sv
// tb_wal_dot_acc: drives a default instance and an ACC_W=8 instance with shared stimulus.
// Expected results come from exact integer sums reduced to each width; a monitor pops them on output transfers.
// Directed phases cover basic sums, backpressure, overflow, clear, async reset and input stalls, then random traffic.
module tb_wal_dot_acc;

    localparam int N = 4;

    logic       clk;
    logic       rst_n;
    logic       clr;
    logic       in_valid;
    logic [7:0] prod;
    logic       out_ready;

    logic       in_ready_a, out_valid_a, ovf_a;
    logic [9:0] sum_a;
    logic [3:0] cnt_a;
    logic       in_ready_b, out_valid_b, ovf_b;
    logic [7:0] sum_b;
    logic [3:0] cnt_b;

    wal_dot_acc #(.N_TERMS(N), .ACC_W(10), .CNT_W(4)) u_dut (
        .clk(clk), .rst_n(rst_n), .clr(clr), .in_valid(in_valid), .in_ready(in_ready_a),
        .prod(prod), .out_valid(out_valid_a), .out_ready(out_ready), .sum(sum_a),
        .ovf(ovf_a), .term_cnt(cnt_a)
    );

    wal_dot_acc #(.N_TERMS(N), .ACC_W(8), .CNT_W(4)) u_dut8 (
        .clk(clk), .rst_n(rst_n), .clr(clr), .in_valid(in_valid), .in_ready(in_ready_b),
        .prod(prod), .out_valid(out_valid_b), .out_ready(out_ready), .sum(sum_b),
        .ovf(ovf_b), .term_cnt(cnt_b)
    );

    int n_checks = 0;
    int n_fail   = 0;
    int exp_sum_a_q[$];
    int exp_ovf_a_q[$];
    int exp_sum_b_q[$];
    int exp_ovf_b_q[$];
    int m_cnt   = 0;
    int m_total = 0;
    bit rand_mode = 0;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // Reference: a dot product is the exact integer total, reduced to the result width.
    function automatic int model_sum(input int total, input int w);
        int mx;
        mx = (1 << w) - 1;
`ifdef WAL_ACC_SAT_EN
        return (total > mx) ? mx : total;
`else
        return total % (1 << w);
`endif
    endfunction

    function automatic int model_ovf(input int total, input int w);
        return (total > (1 << w) - 1) ? 1 : 0;
    endfunction

    task automatic model_clear();
        m_cnt   = 0;
        m_total = 0;
    endtask

    // Present one product until accepted; called and returns at posedge+1.
    task automatic send(input int p);
        int  guard;
        bit  accepted;
        guard    = 0;
        accepted = 1'b0;
        in_valid = 1'b1;
        prod     = p[7:0];
        while (!accepted) begin
            if (rand_mode) out_ready = 1'($urandom_range(0, 1));
            @(negedge clk);
            accepted = in_ready_a;
            @(posedge clk);
            #1;
            guard++;
            if (!accepted && guard > 200) begin
                n_checks++;
                n_fail++;
                $display("FAIL send_timeout: got no accept expected accept of %0d", p);
                break;
            end
        end
        in_valid = 1'b0;
        prod     = 8'($urandom_range(0, 255));
        if (accepted) begin
            m_total += p;
            m_cnt++;
            if (m_cnt == N) begin
                exp_sum_a_q.push_back(model_sum(m_total, 10));
                exp_ovf_a_q.push_back(model_ovf(m_total, 10));
                exp_sum_b_q.push_back(model_sum(m_total, 8));
                exp_ovf_b_q.push_back(model_ovf(m_total, 8));
                check("out_valid_on_last_accept", 32'(out_valid_a), 32'd1);
                model_clear();
            end
            check("term_cnt", 32'(cnt_a), 32'(m_cnt));
        end
    endtask

    task automatic idle(input int n);
        in_valid = 1'b0;
        for (int i = 0; i < n; i++) begin
            if (rand_mode) out_ready = 1'($urandom_range(0, 1));
            prod = 8'($urandom_range(0, 255));
            @(posedge clk);
            #1;
        end
    endtask

    // Monitor: every output transfer is compared against the oldest expected result.
    initial begin
        forever begin
            @(negedge clk);
            if (rst_n && out_valid_a && out_ready && !clr) begin
                if (exp_sum_a_q.size() == 0) begin
                    n_checks++;
                    n_fail++;
                    $display("FAIL unexpected_result: got sum %0d expected no result", sum_a);
                end else begin
                    check("sum_w10", 32'(sum_a), 32'(exp_sum_a_q.pop_front()));
                    check("ovf_w10", 32'(ovf_a), 32'(exp_ovf_a_q.pop_front()));
                    check("sum_w8",  32'(sum_b), 32'(exp_sum_b_q.pop_front()));
                    check("ovf_w8",  32'(ovf_b), 32'(exp_ovf_b_q.pop_front()));
                    check("out_valid_w8", 32'(out_valid_b), 32'd1);
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        rst_n     = 1'b0;
        clr       = 1'b0;
        in_valid  = 1'b0;
        prod      = 8'd0;
        out_ready = 1'b1;
        #2;
        check("rst_in_ready",  32'(in_ready_a),  32'd1);
        check("rst_out_valid", 32'(out_valid_a), 32'd0);
        check("rst_sum",       32'(sum_a),       32'd0);
        check("rst_ovf",       32'(ovf_a),       32'd0);
        check("rst_term_cnt",  32'(cnt_a),       32'd0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;

        // Basic sums, one product per cycle.
        send(0); send(2); send(16); send(25);
        send(49); send(64); send(81); send(100);
        idle(1);

        // Backpressure: result held while the next product waits.
        out_ready = 1'b0;
        for (int i = 0; i < N; i++) send(121);
        in_valid = 1'b1;
        prod     = 8'd9;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            check("stall_in_ready",  32'(in_ready_a),  32'd0);
            check("stall_out_valid", 32'(out_valid_a), 32'd1);
            check("stall_sum",       32'(sum_a),       32'd484);
            @(posedge clk);
            #1;
        end
        out_ready = 1'b1;
        send(9); send(9); send(9); send(9);
        idle(1);

        // Overflow in the narrow instance, then a small sum that must report no overflow.
        for (int i = 0; i < N; i++) send(121);
        for (int i = 0; i < N; i++) send(1);
        idle(1);

        // Clear mid dot product: the concurrent 50 must not be summed.
        send(100); send(100);
        clr      = 1'b1;
        in_valid = 1'b1;
        prod     = 8'd50;
        @(posedge clk);
        #1;
        clr      = 1'b0;
        in_valid = 1'b0;
        model_clear();
        check("clr_term_cnt",  32'(cnt_a),       32'd0);
        check("clr_out_valid", 32'(out_valid_a), 32'd0);
        send(1); send(2); send(3); send(4);
        idle(1);

        // Clear while holding a result: flag drops, sum is retained.
        out_ready = 1'b0;
        for (int i = 0; i < N; i++) send(121);
        clr = 1'b1;
        @(posedge clk);
        #1;
        clr = 1'b0;
        check("clrhold_out_valid", 32'(out_valid_a), 32'd0);
        check("clrhold_in_ready",  32'(in_ready_a),  32'd1);
        check("clrhold_ovf_w8",    32'(ovf_b),       32'd0);
        check("clrhold_sum_w10",   32'(sum_a),       32'd484);
        check("clrhold_sum_w8",    32'(sum_b),       32'(exp_sum_b_q[exp_sum_b_q.size()-1]));
        void'(exp_sum_a_q.pop_back());
        void'(exp_ovf_a_q.pop_back());
        void'(exp_sum_b_q.pop_back());
        void'(exp_ovf_b_q.pop_back());
        out_ready = 1'b1;
        send(1); send(2); send(3); send(4);
        idle(2);

        // Async reset between edges with a partial sum in flight.
        send(2); send(3);
        #2;
        rst_n = 1'b0;
        #1;
        check("arst_term_cnt",  32'(cnt_a),       32'd0);
        check("arst_in_ready",  32'(in_ready_a),  32'd1);
        check("arst_out_valid", 32'(out_valid_a), 32'd0);
        check("arst_sum",       32'(sum_a),       32'd0);
        check("arst_ovf_w8",    32'(ovf_b),       32'd0);
        model_clear();
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        send(5); send(5); send(5); send(5);
        idle(1);

        // Input stalls: in_valid toggles every other cycle.
        for (int p = 1; p <= 4; p++) begin
            send(p);
            idle(1);
        end

        // Random traffic with random gaps and random consumer backpressure.
        rand_mode = 1'b1;
        for (int d = 0; d < 25; d++) begin
            for (int t = 0; t < N; t++) begin
                send(int'($urandom_range(0, 225)));
                idle(int'($urandom_range(0, 2)));
            end
        end
        rand_mode = 1'b0;
        out_ready = 1'b1;
        idle(5);
        check("drain_empty", 32'(exp_sum_a_q.size()), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
